// File: rtl/hazard_interlock_unit_if.sv
// Decode-hazard handshake bundle between the ID stage and the interlock unit.
// Master = pipeline side (drives decode/producer state); slave = interlock.
interface hazard_interlock_unit_if #(
   parameter int NUM_STAGES = 2,
   parameter int REG_AW     = 5,
   parameter int PERF_W     = 16
);
   logic                         id_valid;
   logic [REG_AW-1:0]            id_rs;
   logic [REG_AW-1:0]            id_rt;
   logic                         id_rs_used;
   logic                         id_rt_used;
   logic [NUM_STAGES*REG_AW-1:0] prod_waddr;
   logic [NUM_STAGES-1:0]        prod_wen;
   logic [NUM_STAGES-1:0]        prod_fwd_ok;
   logic                         ext_busy;
   logic                         perf_clr;
   logic                         stall_if_id;
   logic                         bubble_ex;
   logic [NUM_STAGES-1:0]        fwd_rs_sel;
   logic [NUM_STAGES-1:0]        fwd_rt_sel;
   logic [PERF_W-1:0]            stall_cycles;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
             prod_waddr, prod_wen, prod_fwd_ok, ext_busy, perf_clr,
      input  stall_if_id, bubble_ex, fwd_rs_sel, fwd_rt_sel, stall_cycles
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
             prod_waddr, prod_wen, prod_fwd_ok, ext_busy, perf_clr,
      output stall_if_id, bubble_ex, fwd_rs_sel, fwd_rt_sel, stall_cycles
   );
endinterface

// File: rtl/hazard_interlock_unit.sv
// Data-hazard interlock: stalls IF/ID and bubbles ID/EX for NUM_STAGES-i cycles on a match at stage i.
// Latency: detection combinational (same-cycle stall); stall_cycles lags one edge. HIU_FWD_EN enables forwarding selects.
// Backpressure: ext_busy freezes the countdown and holds the pipeline with no bubble.
module hazard_interlock_unit #(
   parameter int NUM_STAGES = 2,
   parameter int REG_AW     = 5,
   parameter int CNT_W      = 3,
   parameter int PERF_W     = 16
) (
   input logic                     clk,
   input logic                     rst,
   hazard_interlock_unit_if.slave  hif
);

   logic [NUM_STAGES-1:0] rs_hit;
   logic [NUM_STAGES-1:0] rt_hit;
   logic [NUM_STAGES-1:0] hazard;
   logic [NUM_STAGES-1:0] fwd_rs;
   logic [NUM_STAGES-1:0] fwd_rt;
   logic [REG_AW-1:0]     waddr;
   logic                  prod_ok;
   logic [CNT_W-1:0]      need;
   logic [CNT_W-1:0]      cnt_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [PERF_W-1:0]     stall_cycles_d;
   logic [PERF_W-1:0]     stall_cycles_q;
   logic                  hold;
   logic                  stall;
   logic                  bubble;

   always_comb begin
      rs_hit  = '0;
      rt_hit  = '0;
      waddr   = '0;
      prod_ok = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         waddr     = hif.prod_waddr[i*REG_AW +: REG_AW];
         prod_ok   = hif.id_valid & hif.prod_wen[i] & (waddr != '0);
         rs_hit[i] = prod_ok & hif.id_rs_used & (waddr == hif.id_rs);
         rt_hit[i] = prod_ok & hif.id_rt_used & (waddr == hif.id_rt);
      end
   end

`ifdef HIU_FWD_EN
   logic [NUM_STAGES-1:0] rs_first;
   logic [NUM_STAGES-1:0] rt_first;

   // Only the nearest producer per operand matters; it either forwards or stalls.
   assign rs_first = rs_hit & (~rs_hit + NUM_STAGES'(1));
   assign rt_first = rt_hit & (~rt_hit + NUM_STAGES'(1));
   assign fwd_rs   = rs_first & hif.prod_fwd_ok;
   assign fwd_rt   = rt_first & hif.prod_fwd_ok;
   assign hazard   = (rs_first | rt_first) & ~hif.prod_fwd_ok;
`else
   logic unused_fwd_ok;

   assign unused_fwd_ok = ^hif.prod_fwd_ok;
   assign fwd_rs        = '0;
   assign fwd_rt        = '0;
   assign hazard        = rs_hit | rt_hit;
`endif

   // Scan downward so the nearest stage (lowest index) sets the final value.
   always_comb begin
      need = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (hazard[i]) begin
            need = CNT_W'(NUM_STAGES - i);
         end
      end
   end

   assign hold   = (cnt_q != '0);
   assign stall  = hold | (need != '0) | hif.ext_busy;
   assign bubble = (hold | (need != '0)) & ~hif.ext_busy;

   always_comb begin
      cnt_d = cnt_q;
      if (!hif.ext_busy) begin
         if (hold) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else if (need != '0) begin
            cnt_d = need - CNT_W'(1);
         end
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (hif.perf_clr) begin
         stall_cycles_d = '0;
      end else if (stall && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + PERF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q          <= '0;
         stall_cycles_q <= '0;
      end else begin
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign hif.stall_if_id  = stall;
   assign hif.bubble_ex    = bubble;
   assign hif.fwd_rs_sel   = fwd_rs;
   assign hif.fwd_rt_sel   = fwd_rt;
   assign hif.stall_cycles = stall_cycles_q;

endmodule

// File: doc/hazard_interlock_unit.md
# hazard_interlock_unit

Parametrised data-hazard interlock for the static MIPS pipeline. It compares the decode-stage source registers against the destination registers of `NUM_STAGES` downstream producer stages. It holds IF/ID and injects bubbles into ID/EX for a computed number of cycles using an internal countdown, and honours a multi-cycle-unit freeze. It also keeps a saturating stall-cycle performance counter, and can optionally report forwarding selects instead of stalling.

## Interface
- `NUM_STAGES`, 2, number of checked producer stages; index 0 = EXE (nearest), 1 = MEM, …
- `REG_AW`, 5, register address width
- `CNT_W`, 3, stall countdown width; must hold `NUM_STAGES`
- `PERF_W`, 16, stall-cycle counter width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `id_valid`  in  1  decode slot holds a real instruction
- `id_rs`, `id_rt`  in  REG_AW  decode source registers
- `id_rs_used`, `id_rt_used`  in  1  source actually read
- `prod_waddr`  in  NUM_STAGES*REG_AW  packed destination addresses; stage i at bits [i*REG_AW +: REG_AW]
- `prod_wen`  in  NUM_STAGES  per-stage register-write enable
- `prod_fwd_ok`  in  NUM_STAGES  stage result available for forwarding (used only with `HIU_FWD_EN`)
- `ext_busy`  in  1  multi-cycle unit busy; whole pipeline frozen
- `perf_clr`  in  1  synchronous clear of perf counter
- `stall_if_id`  out  1  hold PC and IF/ID register
- `bubble_ex`  out  1  load NOP into ID/EX
- `fwd_rs_sel`, `fwd_rt_sel`  out  NUM_STAGES  one-hot forward source, 0 = register file
- `stall_cycles`  out  PERF_W  saturating count of cycles with `stall_if_id` = 1

## Operation
- Match for stage i: `id_valid` & `prod_wen[i]` & `prod_waddr_i != 0` & ((`id_rs_used` & addr == `id_rs`) | (`id_rt_used` & addr == `id_rt`)).
- Register 0 never matches.
- `hazard_i` = match_i, excluding forwardable matches when `HIU_FWD_EN` (see Configuration).
- `need` = `NUM_STAGES` − i for the lowest i with `hazard_i`; `need` = 0 if there is none. The nearest producer dominates.
- States:
  - IDLE: `cnt` = 0. `stall_if_id` = (`need` != 0) | `ext_busy`. `bubble_ex` = (`need` != 0) & ~`ext_busy`.
  - HOLD: `cnt` > 0. `stall_if_id` = 1. `bubble_ex` = ~`ext_busy`. Detection is ignored.
- Transitions, evaluated at the rising edge and only when `ext_busy` = 0:
  - IDLE with `need` > 0 → `cnt` <= `need` − 1, entering HOLD if `need` ≥ 2.
  - HOLD → `cnt` <= `cnt` − 1.
  - `ext_busy` = 1 freezes `cnt`: no load, no decrement.
- Perf counter, per rising edge:
  - `perf_clr` → 0. Clear wins over increment.
  - Otherwise increments when `stall_if_id` = 1, and saturates at all-ones.
- Reset: `cnt` = 0 and `stall_cycles` = 0 immediately. `rst` asserted mid-HOLD aborts the stall. With `id_valid` = 0 after reset, all outputs are 0.

## Timing
- Detection is combinational. `stall_if_id` and `bubble_ex` assert in the same cycle the hazard appears in decode.
- A hazard at stage i produces exactly `NUM_STAGES` − i consecutive stall cycles, unless extended by `ext_busy`.
- `ext_busy` cycles add stall cycles without consuming the countdown. The total is `need` + busy cycles.
- `fwd_*_sel` are combinational and valid the same cycle.
- `stall_cycles` reflects a stall cycle one edge later.

## Configuration
- `HIU_FWD_EN` defined:
  - A match at stage i with `prod_fwd_ok[i]` = 1 does not stall. It sets bit i of `fwd_rs_sel` / `fwd_rt_sel`, choosing the lowest matching i per operand.
  - If the lowest match for an operand is not forwardable, that operand causes a stall with `need` from that stage, and its select is 0.
- Undefined:
  - `prod_fwd_ok` is ignored.
  - Selects are tied to 0.
  - Every match stalls.

## Test plan
- `NUM_STAGES` = 2, no FWD: EXE writes $8 and decode reads rs = $8 → `stall_if_id` = `bubble_ex` = 1 for exactly 2 cycles, then 0; `stall_cycles` = 2.
- MEM-only match on rt = $9 → exactly 1 stall cycle. EXE and MEM both write $9 → 2 cycles, because EXE dominates.
- `prod_waddr` = 0 with `wen` = 1, decode reads $0 → no stall. A match with `id_rs_used` = 0 → no stall.
- EXE hazard, then `ext_busy` held 3 cycles during HOLD → 5 total stall cycles; `bubble_ex` = 0 during the busy cycles.
- `rst` pulsed mid-HOLD → `stall_if_id` = 0 immediately and `stall_cycles` = 0. `PERF_W` = 2: 5 stall cycles → counter saturates at 3; `perf_clr` → 0.
- `HIU_FWD_EN`: EXE match with `prod_fwd_ok[0]` = 1 → no stall, `fwd_rs_sel` = 2'b01. With `prod_fwd_ok[0]` = 0 → 2-cycle stall, `fwd_rs_sel` = 0.
